// File: rtl/seq_det_pkg.sv
// Shared constants, overlap-mode type and sizing helper for the multi-pattern sequence detector.
package seq_det_pkg;

    localparam int PAT_LEN_MAX = 16;
    localparam int NUM_PAT_MAX = 8;

    typedef enum logic {
        MODE_NON_OVL = 1'b0,
        MODE_OVL     = 1'b1
    } ovl_mode_t;

    // Fill counter must reach PAT_LEN itself, hence the +1.
    function automatic int fill_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_lane.sv
// One pattern lane: pattern register, fill counter, registered match flag and match counter.
// Match counter present only when SEQ_DET_CNT_EN is defined; otherwise cnt is tied to zero.
module seq_match_lane
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [PAT_LEN-1:0] PAT_RST = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               overlap_en,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_data,
    input  logic [PAT_LEN-1:0] hist_nxt,
    input  logic               clear_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   cnt
);

    localparam int            FW   = fill_width(PAT_LEN);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] pat;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_nxt;
    logic               hit;
    ovl_mode_t          mode;

    assign mode = overlap_en ? MODE_OVL : MODE_NON_OVL;

    always_comb begin
        fill_nxt = (fill == FULL) ? fill : fill + FW'(1);
        hit      = in_valid && (hist_nxt == pat) && (fill_nxt == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat   <= PAT_RST;
            fill  <= '0;
            match <= 1'b0;
        end else if (pat_load) begin
            pat   <= pat_data;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (in_valid)
                fill <= (hit && mode == MODE_NON_OVL) ? '0 : fill_nxt;
        end
    end

`ifdef SEQ_DET_CNT_EN
    // A load masks the match flag, so it must mask the increment too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear_cnt)
            cnt <= '0;
        else if (hit && !pat_load && cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end
`else
    logic unused_clear_cnt;
    assign unused_clear_cnt = clear_cnt;
    assign cnt = '0;
`endif

endmodule

// File: rtl/multi_seq_detector.sv
// Serial detector for NUM_PAT runtime-loadable patterns sharing one history shift register.
// Optional match counters enabled by defining SEQ_DET_CNT_EN.
module multi_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                         PAT_LEN = 4,
    parameter int                         NUM_PAT = 2,
    parameter int                         CNT_W   = 8,
    parameter logic [NUM_PAT*PAT_LEN-1:0] PAT_RST = 8'h75
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in,
    input  logic                       overlap_en,
    input  logic                       pat_load,
    input  logic [NUM_PAT*PAT_LEN-1:0] pat_data,
    input  logic                       clear_cnt,
    output logic [NUM_PAT-1:0]         match,
    output logic                       op,
    output logic [NUM_PAT*CNT_W-1:0]   match_cnt
);

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_nxt;

    assign hist_nxt = {hist[PAT_LEN-2:0], in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hist <= '0;
        else if (pat_load)
            hist <= '0;
        else if (in_valid)
            hist <= hist_nxt;
    end

    for (genvar k = 0; k < NUM_PAT; k++) begin : g_lane
        seq_match_lane #(
            .PAT_LEN (PAT_LEN),
            .CNT_W   (CNT_W),
            .PAT_RST (PAT_RST[k*PAT_LEN +: PAT_LEN])
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .overlap_en (overlap_en),
            .pat_load   (pat_load),
            .pat_data   (pat_data[k*PAT_LEN +: PAT_LEN]),
            .hist_nxt   (hist_nxt),
            .clear_cnt  (clear_cnt),
            .match      (match[k]),
            .cnt        (match_cnt[k*CNT_W +: CNT_W])
        );
    end

    assign op = |match;

endmodule
